// File: rtl/data_bus_responder.sv
// Responder for the single-cycle CPU data port: word RAM plus an MMIO page
// with a sticky result register, a cycle counter, a UART transmitter and LEDs.
module data_bus_responder #(
  parameter int RAM_WORDS    = 4096,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        done,
  output logic        pass,
  output logic [7:0]  leds
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [29:0] RESULT_WORD = 30'h3FFF_FFFC;
  localparam logic [29:0] CYCLES_WORD = 30'h3FFF_FFFD;
  localparam logic [29:0] UART_WORD   = 30'h3FFF_FFFE;
  localparam logic [29:0] LEDS_WORD   = 30'h3FFF_FFFF;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [31:0]   ram [RAM_WORDS];
  logic [29:0]   word;
  logic          in_ram;
  logic [AW-1:0] ram_index;
  logic          unused_adr_bits;

  logic [31:0]   cycles;
  uart_state_t   state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_count;
  logic [7:0]    tx_byte;
  logic          overflow;
  logic          busy;
  logic          uart_write;

  assign word            = data_adr[31:2];
  assign in_ram          = {2'b00, word} < 32'(RAM_WORDS);
  assign ram_index       = data_adr[AW+1:2];
  assign unused_adr_bits = ^data_adr[1:0];
  assign busy            = (state != IDLE);
  assign uart_write      = mem_write && (word == UART_WORD);

  // RAM contents deliberately survive reset so a program image is not lost.
  always_ff @(posedge clock) begin
    if (mem_write && in_ram) ram[ram_index] <= write_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
      done   <= 1'b0;
      pass   <= 1'b0;
      leds   <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (mem_write && (word == RESULT_WORD) && !done) begin
        done <= 1'b1;
        pass <= (write_data == 32'h1);
      end
      if (mem_write && (word == LEDS_WORD)) leds <= write_data[7:0];
    end
  end

  // UART transmitter; tx is registered so a reset forces the line idle at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baud      <= '0;
      bit_count <= '0;
      tx_byte   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (uart_write && busy) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (uart_write) begin
            tx_byte   <= write_data[7:0];
            tx        <= 1'b0;
            baud      <= '0;
            bit_count <= '0;
            state     <= START;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= tx_byte[0];
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_count == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_count <= bit_count + 3'd1;
              tx        <= tx_byte[bit_count + 3'd1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    read_data = '0;
    if (in_ram) begin
      read_data = ram[ram_index];
    end else begin
      case (word)
        RESULT_WORD: read_data = {30'b0, pass, done};
        CYCLES_WORD: read_data = cycles;
        UART_WORD:   read_data = {30'b0, overflow, busy};
        LEDS_WORD:   read_data = {24'b0, leds};
        default:     read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: register/RAM reads checked inline,
// UART line checked every cycle against a queue of expected tx bits.
module tb_data_bus_responder;

  localparam int CPB = 4;
  localparam logic [31:0] RESULT_ADR = 32'hFFFF_FFF0;
  localparam logic [31:0] CYCLES_ADR = 32'hFFFF_FFF4;
  localparam logic [31:0] UART_ADR   = 32'hFFFF_FFF8;
  localparam logic [31:0] LEDS_ADR   = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        tx;
  logic        done;
  logic        pass;
  logic [7:0]  leds;

  int          checks = 0;
  int          failures = 0;
  logic        tx_queue [$];
  logic        expected_tx;
  logic [31:0] model_cycles;
  logic [31:0] first_read;

  always #10 clock = ~clock;

  data_bus_responder #(.RAM_WORDS(4096), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .read_data(read_data), .tx(tx), .done(done),
    .pass(pass), .leds(leds)
  );

  // Reference cycle count: zero while reset is low, +1 on every edge after.
  always @(posedge clock or negedge reset) begin
    if (!reset) model_cycles <= 32'd0;
    else        model_cycles <= model_cycles + 32'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    mem_write  = we;
    data_adr   = adr;
    write_data = wd;
    @(negedge clock);
    mem_write  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 32'h0000_0100, 32'h0);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] adr, input logic [31:0] expected);
    mem_write = 1'b0;
    data_adr  = adr;
    #1;
    checkOutput(tag, read_data, expected);
  endtask

  // Queue the 10-bit frame cycle by cycle, then issue the UART write.
  task automatic sendFrame(input logic [7:0] b);
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k < CPB)          tx_queue.push_back(1'b0);
      else if (k < 9 * CPB) tx_queue.push_back(b[(k - CPB) / CPB]);
      else                  tx_queue.push_back(1'b1);
    end
    applyStimulus(1'b1, UART_ADR, {24'h0, b});
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (tx_queue.size() > 0) begin
        expected_tx = tx_queue.pop_front();
        checkOutput("tx_frame", 32'(tx), 32'(expected_tx));
      end else begin
        checkOutput("tx_idle", 32'(tx), 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1; mem_write = 1'b0; data_adr = '0; write_data = '0;
    #5 reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_leds", 32'(leds), 32'd0);
    reset = 1'b1;
    readCheck("cycles_release", CYCLES_ADR, 32'd0);
    @(negedge clock);
    readCheck("cycles_release_plus1", CYCLES_ADR, 32'd1);
    readCheck("uart_reset", UART_ADR, 32'd0);
    readCheck("result_reset", RESULT_ADR, 32'd0);

    applyStimulus(1'b1, 32'h0000_0000, 32'hCAFE_F00D);
    applyStimulus(1'b1, 32'h0000_0010, 32'h1234_5678);
    readCheck("ram_10", 32'h0000_0010, 32'h1234_5678);
    readCheck("ram_13", 32'h0000_0013, 32'h1234_5678);
    readCheck("ram_oob_read", 32'h0000_8000, 32'h0);
    applyStimulus(1'b1, 32'h0000_8000, 32'hDEAD_BEEF);
    readCheck("ram_oob_write", 32'h0000_8000, 32'h0);
    readCheck("ram_no_alias", 32'h0000_0000, 32'hCAFE_F00D);
    readCheck("ram_10_kept", 32'h0000_0010, 32'h1234_5678);
    applyStimulus(1'b1, 32'h0000_3FFC, 32'hA5A5_0001);
    readCheck("ram_last", 32'h0000_3FFC, 32'hA5A5_0001);
    readCheck("unmapped", 32'hFFFF_FFEC, 32'h0);

    applyStimulus(1'b1, LEDS_ADR, 32'h0000_01FF);
    checkOutput("leds_port", 32'(leds), 32'h0000_00FF);
    readCheck("leds_read", LEDS_ADR, 32'h0000_00FF);

    data_adr = CYCLES_ADR;
    #1;
    first_read = read_data;
    checkOutput("cycles_model", read_data, model_cycles);
    idle(10);
    data_adr = CYCLES_ADR;
    #1;
    checkOutput("cycles_delta", read_data - first_read, 32'd10);
    applyStimulus(1'b1, CYCLES_ADR, 32'h0);
    readCheck("cycles_write_ignored", CYCLES_ADR, model_cycles);

    applyStimulus(1'b1, RESULT_ADR, 32'h1);
    checkOutput("result_done", 32'(done), 32'd1);
    checkOutput("result_pass", 32'(pass), 32'd1);
    readCheck("result_read", RESULT_ADR, 32'd3);
    applyStimulus(1'b1, RESULT_ADR, 32'h0);
    checkOutput("result_sticky_pass", 32'(pass), 32'd1);
    readCheck("result_sticky_read", RESULT_ADR, 32'd3);

    sendFrame(8'hA5);
    readCheck("uart_busy", UART_ADR, 32'd1);
    idle(9);
    applyStimulus(1'b1, UART_ADR, 32'h3C);
    readCheck("uart_overflow", UART_ADR, 32'd3);
    idle(29);
    readCheck("uart_last_stop", UART_ADR, 32'd3);
    idle(1);
    readCheck("uart_idle_after", UART_ADR, 32'd2);

    // Interrupt a new frame during data bit 3 (a zero) to see tx snap high.
    sendFrame(8'hA5);
    idle(16);
    checkOutput("pre_reset_tx", 32'(tx), 32'd0);
    reset = 1'b0;
    tx_queue.delete();
    #1;
    checkOutput("mid_reset_tx", 32'(tx), 32'd1);
    checkOutput("mid_reset_done", 32'(done), 32'd0);
    checkOutput("mid_reset_pass", 32'(pass), 32'd0);
    checkOutput("mid_reset_leds", 32'(leds), 32'd0);
    readCheck("mid_reset_uart", UART_ADR, 32'd0);
    applyStimulus(1'b1, RESULT_ADR, 32'h1);
    checkOutput("reset_beats_result", 32'(done), 32'd0);
    reset = 1'b1;
    readCheck("cycles_rerelease", CYCLES_ADR, 32'd0);
    @(negedge clock);
    readCheck("cycles_rerelease_plus1", CYCLES_ADR, 32'd1);

    sendFrame(8'h55);
    idle(39);
    readCheck("b2b_final_stop", UART_ADR, 32'd1);
    applyStimulus(1'b1, UART_ADR, 32'h55);
    readCheck("b2b_dropped", UART_ADR, 32'd2);
    sendFrame(8'h55);
    readCheck("b2b_restart", UART_ADR, 32'd3);
    idle(40);

    applyStimulus(1'b1, RESULT_ADR, 32'h2);
    checkOutput("result2_done", 32'(done), 32'd1);
    checkOutput("result2_pass", 32'(pass), 32'd0);
    readCheck("result2_read", RESULT_ADR, 32'd1);

    for (int i = 0; i < 100 && tx_queue.size() > 0; i++) @(negedge clock);
    checkOutput("tx_drain", 32'(tx_queue.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
